// File: rtl/datapath_sequencer_if.sv
// Host-side bundle of the run-control sequencer: command stream, program-word
// stream and the registered instruction-memory write port.
interface datapath_sequencer_if;
  logic        host_cmd_valid;
  logic        host_cmd_ready;
  logic [1:0]  host_cmd;
  logic [31:0] host_cmd_arg;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;

  modport master (
    output host_cmd_valid, host_cmd, host_cmd_arg, load_valid, load_data,
    input  host_cmd_ready, load_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    input  host_cmd_valid, host_cmd, host_cmd_arg, load_valid, load_data,
    output host_cmd_ready, load_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/datapath_sequencer.sv
// Run-control sequencer: program load, RUN/STEP/HALT control, datapath
// clock-enable/clear generation and cycle accounting.
//
// state  | meaning
// IDLE   | waiting for a command after reset or after a LOAD completes
// LOAD   | accepting N program words into instruction memory
// CLR    | one-cycle datapath clear after a LOAD
// RUN    | datapath advancing while no stop condition holds
// HALTED | stopped on host halt, limit/step or breakpoint
module datapath_sequencer #(
  parameter int IMEM_WORDS = 64,
  parameter int CYCLE_W    = 32
) (
  input  logic               clock,
  input  logic               clear_n,
  datapath_sequencer_if.slave bus,
  output logic               dp_enable,
  output logic               dp_clear,
  input  logic [31:0]        pc,
  input  logic               bkpt_en,
  input  logic [31:0]        bkpt_pc,
  output logic [2:0]         state,
  output logic [1:0]         halt_reason,
  output logic               done,
  output logic               cmd_err,
  output logic [CYCLE_W-1:0] cycle_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_CLR    = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  localparam logic [1:0] C_LOAD = 2'd0;
  localparam logic [1:0] C_RUN  = 2'd1;
  localparam logic [1:0] C_STEP = 2'd2;
  localparam logic [1:0] C_HALT = 2'd3;

  localparam logic [1:0] R_NONE  = 2'd0;
  localparam logic [1:0] R_HOST  = 2'd1;
  localparam logic [1:0] R_LIMIT = 2'd2;
  localparam logic [1:0] R_BKPT  = 2'd3;

  localparam int IDX_W = $clog2(IMEM_WORDS + 1);

  logic [2:0]         r_state;
  logic [1:0]         r_reason;
  logic               r_done;
  logic               r_cmd_err;
  logic               r_imem_we;
  logic [31:0]        r_imem_waddr;
  logic [31:0]        r_imem_wdata;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_load_n;
  logic [CYCLE_W-1:0] r_limit;
  logic [CYCLE_W-1:0] r_run_count;
  logic [CYCLE_W-1:0] r_cycle_count;
  logic               r_first;
  logic               r_step;

  logic               w_cmd_ready;
  logic               w_cmd_fire;
  logic               w_load_fire;
  logic               w_halt_req;
  logic               w_lim_hit;
  logic               w_bkpt_hit;
  logic               w_stop;
  logic [1:0]         w_stop_reason;
  logic               w_enable;
  logic [CYCLE_W-1:0] w_run_next;
  logic               w_last;
  logic [CYCLE_W-1:0] w_arg_cyc;
  logic               w_load_bad;
  logic [CYCLE_W-1:0] w_cc_next;

  assign w_cmd_ready = clear_n &&
                       ((r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_HALTED));
  assign w_cmd_fire  = bus.host_cmd_valid && w_cmd_ready;
  assign w_load_fire = (r_state == S_LOAD) && bus.load_valid;
  assign w_arg_cyc   = CYCLE_W'(bus.host_cmd_arg);
  assign w_load_bad  = bus.host_cmd_arg > 32'(IMEM_WORDS);

  assign w_halt_req  = (r_state == S_RUN) && w_cmd_fire && (bus.host_cmd == C_HALT);
  assign w_lim_hit   = (r_limit != '0) && (r_run_count == r_limit);
  // STEP ignores the breakpoint; first suppresses a re-hit on resume.
  assign w_bkpt_hit  = bkpt_en && !r_step && (pc == bkpt_pc) && !r_first;
  assign w_stop      = (r_state == S_RUN) && (w_halt_req || w_lim_hit || w_bkpt_hit);
  assign w_enable    = (r_state == S_RUN) && !w_stop;

  always_comb begin
    w_stop_reason = R_NONE;
    if (w_halt_req)      w_stop_reason = R_HOST;
    else if (w_lim_hit)  w_stop_reason = R_LIMIT;
    else if (w_bkpt_hit) w_stop_reason = R_BKPT;
  end

  // Leaving RUN on the Mth enable avoids an idle RUN cycle before HALTED.
  assign w_run_next = r_run_count + CYCLE_W'(1);
  assign w_last     = w_enable && (r_limit != '0) && (w_run_next == r_limit);
  assign w_cc_next  = (&r_cycle_count) ? r_cycle_count : r_cycle_count + CYCLE_W'(1);

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state       <= S_IDLE;
      r_reason      <= R_NONE;
      r_done        <= 1'b0;
      r_cmd_err     <= 1'b0;
      r_imem_we     <= 1'b0;
      r_imem_waddr  <= '0;
      r_imem_wdata  <= '0;
      r_idx         <= '0;
      r_load_n      <= '0;
      r_limit       <= '0;
      r_run_count   <= '0;
      r_cycle_count <= '0;
      r_first       <= 1'b0;
      r_step        <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cmd_err <= 1'b0;
      r_imem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_HALTED: begin
          if (w_cmd_fire) begin
            case (bus.host_cmd)
              C_LOAD: begin
                if (bus.host_cmd_arg == 32'd0) begin
                  r_done <= 1'b1;
                end else if (w_load_bad) begin
                  r_cmd_err <= 1'b1;
                end else begin
                  r_state  <= S_LOAD;
                  r_idx    <= '0;
                  r_load_n <= IDX_W'(bus.host_cmd_arg);
                end
              end
              C_RUN: begin
                r_state     <= S_RUN;
                r_limit     <= w_arg_cyc;
                r_run_count <= '0;
                r_first     <= 1'b1;
                r_step      <= 1'b0;
              end
              C_STEP: begin
                r_state     <= S_RUN;
                r_limit     <= CYCLE_W'(1);
                r_run_count <= '0;
                r_first     <= 1'b1;
                r_step      <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_LOAD: begin
          if (w_load_fire) begin
            r_imem_we    <= 1'b1;
            r_imem_waddr <= 32'(r_idx) << 2;
            r_imem_wdata <= bus.load_data;
            r_idx        <= r_idx + IDX_W'(1);
            if (r_idx == r_load_n - IDX_W'(1)) r_state <= S_CLR;
          end
        end
        S_CLR: begin
          r_cycle_count <= '0;
          r_reason      <= R_NONE;
          r_done        <= 1'b1;
          r_state       <= S_IDLE;
        end
        S_RUN: begin
          if (w_cmd_fire && (bus.host_cmd != C_HALT)) r_cmd_err <= 1'b1;
          if (w_enable) begin
            r_run_count   <= w_run_next;
            r_cycle_count <= w_cc_next;
            r_first       <= 1'b0;
          end
          if (w_stop) begin
            r_state  <= S_HALTED;
            r_reason <= w_stop_reason;
            r_done   <= 1'b1;
          end else if (w_last) begin
            r_state  <= S_HALTED;
            r_reason <= R_LIMIT;
            r_done   <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.host_cmd_ready = w_cmd_ready;
  assign bus.load_ready     = (r_state == S_LOAD);
  assign bus.imem_we        = r_imem_we;
  assign bus.imem_waddr     = r_imem_waddr;
  assign bus.imem_wdata     = r_imem_wdata;

  assign dp_enable   = w_enable;
  assign dp_clear    = (r_state == S_CLR);
  assign state       = r_state;
  assign halt_reason = r_reason;
  assign done        = r_done;
  assign cmd_err     = r_cmd_err;
  assign cycle_count = r_cycle_count;

endmodule
